// File: rtl/aes_dec_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES decryption round engine.
package aes_dec_pkg;

    localparam int NUM_MID_ROUNDS = 9;
    localparam int STATE_W        = 128;
    localparam int DATA_W         = 129;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[1] ^ x[4] ^ x[6], x[0] ^ x[3] ^ x[5], x[7] ^ x[2] ^ x[4],
                x[6] ^ x[1] ^ x[3], x[5] ^ x[0] ^ x[2], x[4] ^ x[7] ^ x[1],
                x[3] ^ x[6] ^ x[0], x[2] ^ x[5] ^ x[7]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes_dec_prims.sv
// Byte-level AES decryption primitives: round-key add, inverse row shift, inverse S-box.
module keyAdd
    import aes_dec_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] key,
    output logic [STATE_W-1:0] result
);
    assign result = state ^ key;
endmodule

// Byte i sits at bits [127-8i -: 8]; row = i % 4, column = i / 4.
module invShiftRows
    import aes_dec_pkg::*;
(
    input  logic [STATE_W-1:0] din,
    output logic [STATE_W-1:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(r+4*((c+r)%4)) -: 8] = din[127-8*(r+4*c) -: 8];
        end
    end
endmodule

module inv_s_box_16
    import aes_dec_pkg::*;
(
    input  logic [STATE_W-1:0] din,
    output logic [STATE_W-1:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[127-8*i -: 8] = gf_inv(inv_affine(din[127-8*i -: 8]));
    end
endmodule

// File: rtl/inv_mix_columns.sv
// Combinational InvMixColumns over all four columns of the 128-bit state.
module inv_mix_columns
    import aes_dec_pkg::*;
(
    input  logic [STATE_W-1:0] din,
    output logic [STATE_W-1:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];

        assign dout[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                     gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign dout[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                     gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign dout[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                     gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign dout[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                     gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
endmodule

// File: rtl/dec_round_engine.sv
// Iterative AES-128 decryption: nine middle rounds plus final key add on one round of logic.
module dec_round_engine
    import aes_dec_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [3:0]         key_idx,
    input  logic [STATE_W-1:0] round_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and out_data is held until taken.

    localparam logic [3:0] LOAD_CNT = 4'(NUM_MID_ROUNDS);

    dec_state_e         state;
    logic [STATE_W-1:0] st_q;
    logic               tag_q;
    logic [3:0]         cnt;

    logic [STATE_W-1:0] ark;
    logic [STATE_W-1:0] imc;
    logic [STATE_W-1:0] isr;
    logic [STATE_W-1:0] round_out;

    keyAdd          u_key_add (.state(st_q), .key(round_key), .result(ark));
    inv_mix_columns u_imc     (.din(ark), .dout(imc));
    invShiftRows    u_isr     (.din(imc), .dout(isr));
    inv_s_box_16    u_isb     (.din(isr), .dout(round_out));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            st_q      <= '0;
            tag_q     <= 1'b0;
            cnt       <= 4'd0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            key_idx   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        st_q     <= in_data[STATE_W-1:0];
                        tag_q    <= in_data[STATE_W];
                        cnt      <= LOAD_CNT;
                        key_idx  <= LOAD_CNT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    st_q <= round_out;
                    cnt  <= cnt - 4'd1;
                    // key_idx tracks the counter so round_key is ready for the next cycle.
                    if (cnt == 4'd1) begin
                        key_idx <= 4'd0;
                        state   <= ST_FINAL;
                    end else begin
                        key_idx <= cnt - 4'd1;
                    end
                end
                ST_FINAL: begin
                    st_q      <= ark;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_data = {tag_q, st_q};

endmodule

// File: tb/tb_dec_round_engine.sv
// Bench for dec_round_engine: forward AES-128 model produces ciphertexts, DUT must recover plaintext.
module tb_dec_round_engine;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic [128:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [128:0] out_data;
    logic         busy;

    dec_round_engine dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_idx(key_idx), .round_key(round_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk       [11];
    logic [3:0]   key_log  [$];
    logic [128:0] exp_q    [$];

    // Key storage: answers key_idx combinationally.
    always_comb begin
        round_key = '0;
        if (key_idx <= 4'd10) round_key = rk[key_idx];
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]     = v;
            inv_sbox[v] = 8'(x);
        end
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] t;
        for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
        return t;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*((c+rw)%4)) -: 8];
        return t;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return t;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // The engine expects the ciphertext with its first inverse round already applied.
    function automatic logic [127:0] first_inv(input logic [127:0] ct);
        logic [127:0] s = ct ^ rk[10];
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[127-8*(rw+4*((c+rw)%4)) -: 8] = s[127-8*(rw+4*c) -: 8];
        for (int i = 0; i < 16; i++) s[127-8*i -: 8] = inv_sbox[t[127-8*i -: 8]];
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_block(input logic [128:0] d, output int lat,
                               output logic [128:0] res, output bit ok);
        int g = 0;
        ok  = 1'b1;
        lat = -1;
        res = '0;
        key_log.delete();
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                lat = k;
                res = out_data;
                break;
            end
            key_log.push_back(key_idx);
            @(negedge clk);
        end
        if (lat < 0) ok = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL reset_key_idx: got %0d expected 0", key_idx); end
        n_checks++; if (out_data !== 129'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    endtask

    task automatic test_c1(input logic tag);
        int lat; logic [128:0] res; bit ok;
        key_expand(C1_KEY);
        drive_block({tag, first_inv(C1_CT)}, lat, res, ok);
        n_checks++; if (!ok || lat != 10) begin n_fail++; $display("FAIL c1_latency tag=%b: got %0d expected 10", tag, lat); end
        n_checks++; if (res !== {tag, C1_PT}) begin n_fail++; $display("FAIL c1_data tag=%b: got %h expected %h", tag, res, {tag, C1_PT}); end
    endtask

    task automatic test_key_sequence();
        int lat; logic [128:0] res; bit ok;
        logic [3:0] e;
        key_expand(C1_KEY);
        drive_block({1'b0, first_inv(C1_CT)}, lat, res, ok);
        n_checks++; if (key_log.size() != 10) begin n_fail++; $display("FAIL keyseq_len: got %0d expected 10", key_log.size()); end
        for (int i = 0; i < 10 && i < key_log.size(); i++) begin
            e = (i < 9) ? 4'(9 - i) : 4'd0;
            n_checks++; if (key_log[i] !== e) begin n_fail++; $display("FAIL keyseq[%0d]: got %0d expected %0d", i, key_log[i], e); end
        end
    endtask

    task automatic test_random();
        int lat; logic [128:0] res; bit ok;
        logic [127:0] key, pt;
        logic tag;
        for (int n = 0; n < 6; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tag = 1'($urandom_range(0, 1));
            key_expand(key);
            drive_block({tag, first_inv(encrypt(pt))}, lat, res, ok);
            n_checks++; if (!ok || lat != 10) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 10", n, lat); end
            n_checks++; if (res !== {tag, pt}) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", n, res, {tag, pt}); end
        end
    endtask

    task automatic test_stall();
        logic [127:0] pt;
        logic [128:0] exp_d;
        int g = 0;
        key_expand(C1_KEY);
        pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_d = {1'b1, pt};
        @(negedge clk);
        in_data = {1'b1, first_inv(encrypt(pt))}; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 30) begin @(negedge clk); g++; end
        n_checks++; if (!out_valid) begin n_fail++; $display("FAIL stall_reach_done: out_valid got %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, out_data, exp_d); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            in_valid = (i % 2 == 0);
            in_data  = {1'b0, $urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [128:0] res; bit ok;
        logic [127:0] pt;
        int g = 0;
        int seen = 0;
        key_expand(C1_KEY);
        @(negedge clk);
        in_data = {1'b1, first_inv(C1_CT)}; in_valid = 1'b1; out_ready = 1'b1;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (key_idx !== 4'd5 && g < 20) begin @(negedge clk); g++; end
        n_checks++; if (key_idx !== 4'd5) begin n_fail++; $display("FAIL rstmid_reach_round5: key_idx got %0d expected 5", key_idx); end
        n_rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL rstmid_key_idx: got %0d expected 0", key_idx); end
        @(negedge clk);
        n_rst = 1'b1;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        drive_block({1'b0, first_inv(encrypt(pt))}, lat, res, ok);
        n_checks++; if (!ok || res !== {1'b0, pt}) begin n_fail++; $display("FAIL rstmid_after_data: got %h expected %h", res, {1'b0, pt}); end

        // Reset while DONE is stalled: the block must vanish.
        @(negedge clk);
        in_data = {1'b0, first_inv(C1_CT)}; in_valid = 1'b1; out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 30) begin @(negedge clk); g++; end
        n_rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstdone_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstdone_no_output: out_valid cycles got %0d expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 4;
        logic [128:0] blk [N];
        logic [128:0] expd [N];
        logic [127:0] pt;
        logic [128:0] e;
        int acc_t [$];
        int idx = 0;
        int nout = 0;
        bit just_acc = 1'b0;
        key_expand({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < N; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            expd[i] = {1'(i % 2), pt};
            blk[i]  = {1'(i % 2), first_inv(encrypt(pt))};
        end
        exp_q.delete();
        @(negedge clk);
        in_data = blk[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 12 * N + 30 && nout < N; k++) begin
            if (just_acc) begin
                just_acc = 1'b0;
                idx++;
                if (idx < N) in_data = blk[idx];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", nout, out_data, e); end
                nout++;
            end
            if (in_valid && in_ready) begin
                acc_t.push_back(cyc);
                exp_q.push_back(expd[idx]);
                just_acc = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (nout != N) begin n_fail++; $display("FAIL b2b_count: got %0d outputs expected %0d", nout, N); end
        for (int i = 1; i < acc_t.size(); i++) begin
            n_checks++; if (acc_t[i] - acc_t[i-1] != 12) begin n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected 12", i, acc_t[i] - acc_t[i-1]); end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_c1(1'b0);
        test_c1(1'b1);
        test_key_sequence();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_round_engine.md
DEC_ROUND_ENGINE -- requirements
Module: dec_round_engine

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, in_data holds a block whose first inverse round is already applied.
REQ-004 SHALL have port in_ready, output, 1, engine accepts a block this cycle.
REQ-005 SHALL have port in_data, input, 129, [127:0] state after first inverse round, [128] tag bit.
REQ-006 SHALL have port key_idx, output, 4, round-key index requested from key storage.
REQ-007 SHALL have port round_key, input, 128, round key for key_idx, valid combinationally in the same cycle.
REQ-008 SHALL have port out_valid, output, 1, out_data holds a finished plaintext block.
REQ-009 SHALL have port out_ready, input, 1, consumer takes out_data this cycle.
REQ-010 SHALL have port out_data, output, 129, [127:0] plaintext, [128] tag.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ROUND, FINAL and DONE.
REQ-013 SHALL drive in_ready high only in IDLE.
REQ-014 In IDLE, in_valid high SHALL capture in_data[127:0] into the state register and in_data[128] into the tag register, load round counter with 9, and go to ROUND.
REQ-015 key_idx SHALL equal the round counter in ROUND, 0 in FINAL, and 0 in IDLE and DONE.
REQ-016 Each ROUND cycle SHALL update state <= InvSubBytes(InvShiftRows(InvMixColumns(state XOR round_key))).
REQ-017 Each ROUND cycle SHALL decrement the counter.
REQ-018 ROUND SHALL go to FINAL on the cycle processed with counter = 1, giving exactly 9 ROUND cycles using keys 9 down to 1.
REQ-019 FINAL SHALL update state <= state XOR round_key (key 0), then go to DONE.
REQ-020 DONE SHALL hold out_valid high with out_data stable until out_ready is high, then go to IDLE on that edge.
REQ-021 Latency SHALL be: out_valid rises exactly 10 clock edges after the accepting edge.
REQ-022 The tag bit SHALL pass through unmodified and SHALL NOT affect the arithmetic.
REQ-023 out_data SHALL come directly from the registers, with no combinational path from in_data or round_key.
REQ-024 in_valid SHALL be ignored outside IDLE; no queuing and no overwrite of a block in flight.
REQ-025 out_ready high outside DONE SHALL have no effect.
REQ-026 out_ready held low in DONE SHALL stall indefinitely with no data change.
REQ-027 Back-to-back operation SHALL be: one IDLE cycle minimum between out_valid falling and the next acceptance.

Reset
REQ-028 n_rst low SHALL immediately force IDLE and clear the state, tag and counter registers to 0.
REQ-029 n_rst low SHALL immediately drive out_valid = 0, busy = 0, in_ready = 1 and key_idx = 0.
REQ-030 Reset asserted mid-ROUND, mid-FINAL or in DONE SHALL discard the block with no output; the first edge after release behaves as IDLE.

Structure
REQ-031 Package aes_dec_pkg SHALL hold the FSM state enum.
REQ-032 aes_dec_pkg SHALL hold the constants NUM_MID_ROUNDS = 9, STATE_W = 128 and DATA_W = 129.
REQ-033 InvMixColumns SHALL be one sub-module, inv_mix_columns: combinational, 128-in/128-out, GF(2^8) multiplies by 0e/0b/0d/09 per column.
REQ-034 The block SHALL reuse the existing keyAdd, invShiftRows and inv_s_box_16 for the remaining datapath.
REQ-035 The datapath SHALL contain only one round of combinational logic, iterated.

Verification
REQ-036 FIPS-197 C.1: drive in_data = {1'b0, C.1 round-1 state after InvSubBytes} and a key table of the C.1 expanded keys -> out_data = {1'b0, 00112233445566778899aabbccddeeff}, out_valid 10 edges after acceptance.
REQ-037 Same vector with tag = 1 -> out_data[128] = 1 and out_data[127:0] unchanged.
REQ-038 Log key_idx during one block -> sequence 9,8,7,6,5,4,3,2,1 then 0.
REQ-039 Hold out_ready = 0 for 5 cycles in DONE -> out_valid stays 1, out_data constant, in_ready 0, and in_valid pulses ignored.
REQ-040 Assert n_rst low at ROUND counter = 5 -> same cycle out_valid = 0, busy = 0, in_ready = 1; a new block accepted after release decrypts correctly.
REQ-041 Hold in_valid high continuously with out_ready = 1 -> blocks accepted every 12 cycles, each output correct.
